// File: rtl/uscu_pkg.sv
// Shared definitions for the stochastic compute units: default precision,
// window length and the stochastic-to-binary converter state encoding.
`ifndef INWD
`define INWD 8
`endif

package uscu_pkg;

  // Default bitstream precision; a conversion window is 2^DATAWD samples.
  localparam int unsigned DATAWD_DFLT = `INWD;
  localparam int unsigned WIN         = 2 ** DATAWD_DFLT;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } ustb_state_t;

endpackage

// File: rtl/ustream_to_bin_if.sv
// Handshake bundle between a bitstream producer/result consumer and the
// stochastic-to-binary converter.
//   master: drives iStart/iEn/iBit/iAck, observes oB/oValid/oBusy
//   slave : the converter side
interface ustream_to_bin_if #(
  parameter int unsigned DATAWD = uscu_pkg::DATAWD_DFLT
);

  logic              iStart;
  logic              iEn;
  logic              iBit;
  logic              iAck;
  logic [DATAWD:0]   oB;
  logic              oValid;
  logic              oBusy;

  modport master (
    output iStart, iEn, iBit, iAck,
    input  oB, oValid, oBusy
  );

  modport slave (
    input  iStart, iEn, iBit, iAck,
    output oB, oValid, oBusy
  );

endinterface

// File: rtl/ustream_to_bin.sv
// Unipolar stochastic-to-binary converter. Counts ones in a window of
// 2^DATAWD qualified samples and presents the count with a valid/ack
// handshake.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus.iStart : start a window (IDLE, or DONE to restart)
//   bus.iEn    : sample qualifier for bus.iBit
//   bus.iBit   : stochastic input bit
//   bus.iAck   : consumer acknowledges result in DONE
//   bus.oB     : result 0..2^DATAWD, updated only on entry to DONE
//   bus.oValid : fresh unacknowledged result
//   bus.oBusy  : window in progress
module ustream_to_bin
  import uscu_pkg::*;
#(
  parameter int unsigned DATAWD = uscu_pkg::DATAWD_DFLT
) (
  input  logic                clk,
  input  logic                rst_n,
  ustream_to_bin_if.slave     bus
);

  localparam int unsigned OW = DATAWD + 1;

  localparam logic [1:0] S_IDLE = 2'(IDLE);
  localparam logic [1:0] S_ACC  = 2'(ACC);
  localparam logic [1:0] S_DONE = 2'(DONE);

  localparam logic [DATAWD-1:0] SMP_LAST = '1;

  logic [1:0]        state_q, state_d;
  logic [OW-1:0]     ones_q, ones_d;
  logic [DATAWD-1:0] smp_q, smp_d;
  logic [OW-1:0]     b_q, b_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ones_q  <= '0;
      smp_q   <= '0;
      b_q     <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ones_q  <= ones_d;
      smp_q   <= smp_d;
      b_q     <= b_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  // Next state, counter updates and next values of the output registers.
  always_comb begin
    state_d = state_q;
    ones_d  = ones_q;
    smp_d   = smp_q;
    b_d     = b_q;
    valid_d = 1'b0;
    busy_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.iStart) begin
          state_d = S_ACC;
          ones_d  = '0;
          smp_d   = '0;
          busy_d  = 1'b1;
        end
      end

      S_ACC: begin
        busy_d = 1'b1;
        if (bus.iEn) begin
          ones_d = ones_q + OW'(bus.iBit);
          // smp_q wraps to 0 on the last sample, ready for the next window
          smp_d  = smp_q + DATAWD'(1);
          if (smp_q == SMP_LAST) begin
            state_d = S_DONE;
            b_d     = ones_q + OW'(bus.iBit);
            valid_d = 1'b1;
            busy_d  = 1'b0;
          end
        end
      end

      S_DONE: begin
        valid_d = 1'b1;
        // A restart also consumes the pending result
        if (bus.iStart) begin
          state_d = S_ACC;
          ones_d  = '0;
          smp_d   = '0;
          valid_d = 1'b0;
          busy_d  = 1'b1;
        end else if (bus.iAck) begin
          state_d = S_IDLE;
          valid_d = 1'b0;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.oB     = b_q;
  assign bus.oValid = valid_q;
  assign bus.oBusy  = busy_q;

endmodule

// File: doc/ustream_to_bin.md
# ustream_to_bin

Unipolar stochastic-to-binary converter. It counts the ones in an incoming stochastic bitstream over a fixed window of 2^DATAWD valid samples and presents the count as a binary value with a valid/ack handshake. It is the receiving end of the stochastic compute units (multipliers, adders) and turns their output streams back into binary for readout or for reloading into the next stage's binary operand register.

## Interface
- DATAWD, default `INWD (8 if undefined): bitstream precision; the window is 2^DATAWD valid samples.

- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- iStart  in  1  start a new conversion window.
- iEn  in  1  sample qualifier; iBit is counted only when iEn=1.
- iBit  in  1  stochastic input bit.
- iAck  in  1  consumer acknowledges the result.
- oB  out  DATAWD+1  conversion result in the range 0..2^DATAWD.
- oValid  out  1  oB holds a fresh, unacknowledged result.
- oBusy  out  1  a window is in progress.

## Operation
- Decided: one clock, clk. Reset rst_n is asynchronous and active-low.
- FSM states: IDLE, ACC, DONE. Reset state is IDLE.
- Reset values: oB=0, oValid=0, oBusy=0. Internal counters are also 0.
- IDLE:
  - iStart=1 → ACC. Clear the ones counter onesCnt (DATAWD+1 bits) and the sample counter smpCnt (DATAWD bits).
  - iBit is not sampled in the start cycle.
- ACC:
  - oBusy=1.
  - Each cycle with iEn=1: onesCnt += iBit, smpCnt += 1.
  - When iEn=1 and smpCnt = 2^DATAWD−1, that is the last sample. Next cycle: oB = final onesCnt (including the last bit), oValid=1, state → DONE.
  - iEn=0 cycles are neither counted nor advance the window.
  - iStart and iAck are ignored in ACC.
- DONE:
  - oValid=1, oBusy=0.
  - iAck=1 → IDLE, and oValid=0 next cycle.
  - iStart=1 → ACC with counters cleared, and oValid=0 next cycle.
  - If iStart and iAck are both 1, iStart wins: go to ACC, result is treated as consumed.
- oB is updated only on entry to DONE. It holds the last result through IDLE and ACC until the next completion.
- Arithmetic:
  - onesCnt is DATAWD+1 bits, so an all-ones window yields exactly 2^DATAWD with no saturation or wrap.
  - smpCnt wraps naturally from 2^DATAWD−1 to 0 at window end.
- Reset mid-operation: from any state, immediately return to IDLE with all outputs 0. A partial window is discarded.

## Timing
- Start pulse in cycle 0 with iEn held at 1: samples are taken in cycles 1..2^DATAWD, and oValid rises in cycle 2^DATAWD+1.
- Each iEn=0 cycle during ACC adds one cycle of latency.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Back-to-back conversions: iStart in the first DONE cycle gives a throughput of one result per 2^DATAWD+1 cycles.
- iStart is level-sampled. Holding it high in DONE restarts once, and it is ignored while in ACC.

## Structure
- Shared package uscu_pkg:
  - DATAWD default.
  - the state enum type ustb_state_t {IDLE, ACC, DONE}.
  - the localparam WIN = 2^DATAWD.
- No sub-module is needed. The FSM, the two counters and the result register live in one module of roughly 120–150 lines.
- Optional: factor the gated ones counter as ucnt_ones if it is reused by a bipolar variant later.

## Test plan
Use DATAWD=4 (window of 16 samples).
- All ones: iStart at cycle 0, iEn=1, iBit=1 → oValid=1 at cycle 17, oB=16, oBusy=1 during cycles 1..16.
- All zeros, and alternating 1,0: → oB=0 and oB=8 respectively, each with oValid at cycle 17.
- iEn gaps: iEn=0 for 5 cycles inside the window, iBit=1 during the gap and 0 otherwise → oB=0, oValid delayed to cycle 22.
- Handshake:
  - oValid stays held until iAck, then falls the next cycle with oB retained.
  - iStart and iAck together in DONE → ACC, oValid=0.
  - iStart during ACC → no effect on the count.
- Reset mid-window: drop rst_n at sample 9 → oB=0, oValid=0, oBusy=0 asynchronously. A new iStart then gives a full, correct 16-sample result.
- End-to-end: drive iBit from a 4-bit Sobol comparator against B=11, with iEn always 1 → oB=11.
